lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/load_align.sv | 40 ++++
 rtl/lsu_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller.
//   - funct3 width codes for loads and stores
//   - FSM state enum
//   - misalignment helper used at accept time
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    // Stores with an unknown width code are flagged as misaligned so they never reach memory.
    // Loads with an unknown width code go through and extract to zero.
    function automatic logic is_misaligned(input logic       is_load,
                                           input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic mis;
        mis = 1'b0;
        if (is_load) begin
            if (funct3 == F3_W)                        mis = (offset != 2'b00);
            else if (funct3 == F3_H || funct3 == F3_HU) mis = offset[0];
        end else begin
            if (funct3 == F3_W)      mis = (offset != 2'b00);
            else if (funct3 == F3_H) mis = offset[0];
            else if (funct3 != F3_B) mis = 1'b1;
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction and extension (combinational).
//   data   : 32-bit word returned by the D-cache
//   funct3 : load width code
//   offset : byte offset within the word (addr[1:0])
//   result : aligned, sign/zero-extended load value (0 for unknown funct3)
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'b00:   byte_sel = data[7:0];
            2'b01:   byte_sel = data[15:8];
            2'b10:   byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        half_sel = offset[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        result = 32'h0;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_W:    result = data;
            F3_BU:   result = {24'h0, byte_sel};
            F3_HU:   result = {16'h0, half_sel};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one EX-stage memory op at a time, issues a D-cache
// request, aligns load data and produces a one-cycle writeback or misalignment pulse.
//   clk, rst_n                   : clock, async active-low reset
//   ex_*                         : EX-stage op (valid, load/store, funct3, addr, wdata, rd)
//   lsu_stall                    : holds the pipeline while an op is in flight
//   wb_valid/wb_rd/wb_data       : load writeback, one cycle in DONE
//   misalign_exc/exc_addr        : misaligned-access pulse and faulting address
//   mem_req/we/addr/wdata/be     : D-cache request, held stable until mem_ready
//   mem_ready/mem_rvalid/rdata   : D-cache handshake and load return
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic                  ex_is_store,
    input  logic [2:0]            ex_funct3,
    input  logic [DATA_WIDTH-1:0] ex_addr,
    input  logic [DATA_WIDTH-1:0] ex_wdata,
    input  logic [4:0]            ex_rd,
    output logic                  lsu_stall,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  misalign_exc,
    output logic [DATA_WIDTH-1:0] exc_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] ldata_q, ldata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [4:0]            rd_q, rd_d;
    logic                  is_load_q, is_load_d;
    logic                  exc_q, exc_d;

    logic                  op;
    logic                  op_is_load;
    logic [DATA_WIDTH-1:0] aligned;

    // Load wins when both type flags are set.
    assign op         = ex_valid && (ex_is_load || ex_is_store);
    assign op_is_load = ex_is_load;

    load_align u_load_align (
        .data   (mem_rdata),
        .funct3 (funct3_q),
        .offset (addr_q[1:0]),
        .result (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            ldata_q   <= '0;
            funct3_q  <= 3'b000;
            rd_q      <= 5'd0;
            is_load_q <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ldata_q   <= ldata_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            is_load_q <= is_load_d;
            exc_q     <= exc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ldata_d      = ldata_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        is_load_d    = is_load_q;
        exc_d        = exc_q;

        lsu_stall    = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = '0;
        misalign_exc = 1'b0;
        exc_addr     = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = 4'b0000;

        case (state_q)
            StIdle: begin
                if (op) begin
                    addr_d    = ex_addr;
                    wdata_d   = ex_wdata;
                    funct3_d  = ex_funct3;
                    rd_d      = ex_rd;
                    is_load_d = op_is_load;
                    exc_d     = is_misaligned(op_is_load, ex_funct3, ex_addr[1:0]);
                    lsu_stall = 1'b1;
                    state_d   = exc_d ? StDone : StReq;
                end
            end
            StReq: begin
                lsu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = !is_load_q;
                mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
                if (is_load_q) begin
                    mem_be = 4'b1111;
                end else begin
                    case (funct3_q)
                        F3_B: begin
                            mem_be    = 4'b0001 << addr_q[1:0];
                            mem_wdata = {4{wdata_q[7:0]}};
                        end
                        F3_H: begin
                            mem_be    = 4'b0011 << addr_q[1:0];
                            mem_wdata = {2{wdata_q[15:0]}};
                        end
                        F3_W: begin
                            mem_be    = 4'b1111;
                            mem_wdata = wdata_q;
                        end
                        default: ;
                    endcase
                end
                if (mem_ready) state_d = is_load_q ? StWait : StDone;
            end
            StWait: begin
                lsu_stall = 1'b1;
                if (mem_rvalid) begin
                    ldata_d = aligned;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (exc_q) begin
                    misalign_exc = 1'b1;
                    exc_addr     = addr_q;
                end else if (is_load_q) begin
                    wb_valid = 1'b1;
                    wb_rd    = rd_q;
                    wb_data  = ldata_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Accept-time stall is combinational on ex_valid; keep it low while held in reset.
        if (!rst_n) lsu_stall = 1'b0;
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        lsu_stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_exc;
    logic [31:0] exc_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    lsu_ctrl #(.DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_funct3    (ex_funct3),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .lsu_stall    (lsu_stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .misalign_exc (misalign_exc),
        .exc_addr     (exc_addr),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ready    (mem_ready),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        ex_valid    = 1'b1;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct3   = f3;
        ex_addr     = a;
        ex_wdata    = wd;
        ex_rd       = rd;
    endtask

    task automatic run_load(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] rdata,
                            input logic [4:0] rd, input logic [31:0] exp);
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        accept(1'b1, st, f3, a, 32'h0, rd);
        #1 chk({tag, "_stall_accept"}, {31'h0, lsu_stall}, 32'd1);
        step();                                      // REQ
        ex_valid = 1'b0;
        chk({tag, "_req"}, {31'h0, mem_req}, 32'd1);
        chk({tag, "_we"}, {31'h0, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        step();                                      // WAIT
        chk({tag, "_wait_stall"}, {31'h0, lsu_stall}, 32'd1);
        chk({tag, "_wait_wbv"}, {31'h0, wb_valid}, 32'd0);
        step();                                      // DONE, 3 cycles after accept
        chk({tag, "_wbv"}, {31'h0, wb_valid}, 32'd1);
        chk({tag, "_wbdata"}, wb_data, exp);
        chk({tag, "_wbrd"}, {27'h0, wb_rd}, {27'h0, rd});
        chk({tag, "_done_stall"}, {31'h0, lsu_stall}, 32'd0);
        step();                                      // IDLE
        chk({tag, "_wbv_drop"}, {31'h0, wb_valid}, 32'd0);
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input int hold);
        mem_ready = (hold == 0);
        accept(1'b0, 1'b1, f3, a, wd, 5'd0);
        #1 chk({tag, "_stall_accept"}, {31'h0, lsu_stall}, 32'd1);
        step();                                      // REQ
        ex_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_req"}, {31'h0, mem_req}, 32'd1);
            chk({tag, "_hold_be"}, {28'h0, mem_be}, {28'h0, exp_be});
            chk({tag, "_hold_wdata"}, mem_wdata, exp_wd);
            chk({tag, "_hold_addr"}, mem_addr, {a[31:2], 2'b00});
            step();
        end
        mem_ready = 1'b1;
        chk({tag, "_req"}, {31'h0, mem_req}, 32'd1);
        chk({tag, "_we"}, {31'h0, mem_we}, 32'd1);
        chk({tag, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
        chk({tag, "_wdata"}, mem_wdata, exp_wd);
        chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        step();                                      // DONE
        chk({tag, "_done_stall"}, {31'h0, lsu_stall}, 32'd0);
        chk({tag, "_done_req"}, {31'h0, mem_req}, 32'd0);
        chk({tag, "_done_wbv"}, {31'h0, wb_valid}, 32'd0);
        chk({tag, "_done_exc"}, {31'h0, misalign_exc}, 32'd0);
        step();                                      // IDLE
    endtask

    task automatic run_mis(input string tag, input logic ld, input logic [2:0] f3,
                           input logic [31:0] a);
        mem_ready = 1'b1;
        accept(ld, !ld, f3, a, 32'h5555_5555, 5'd3);
        #1 chk({tag, "_stall_accept"}, {31'h0, lsu_stall}, 32'd1);
        step();                                      // DONE
        ex_valid = 1'b0;
        chk({tag, "_exc"}, {31'h0, misalign_exc}, 32'd1);
        chk({tag, "_exc_addr"}, exc_addr, a);
        chk({tag, "_req"}, {31'h0, mem_req}, 32'd0);
        chk({tag, "_wbv"}, {31'h0, wb_valid}, 32'd0);
        step();                                      // IDLE
        chk({tag, "_exc_drop"}, {31'h0, misalign_exc}, 32'd0);
        chk({tag, "_req_idle"}, {31'h0, mem_req}, 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        ex_valid    = 1'b0;
        ex_is_load  = 1'b0;
        ex_is_store = 1'b0;
        ex_funct3   = 3'b000;
        ex_addr     = 32'h0;
        ex_wdata    = 32'h0;
        ex_rd       = 5'd0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'h0;

        #1;
        chk("rst_stall", {31'h0, lsu_stall}, 32'd0);
        chk("rst_req", {31'h0, mem_req}, 32'd0);
        chk("rst_we", {31'h0, mem_we}, 32'd0);
        chk("rst_be", {28'h0, mem_be}, 32'd0);
        chk("rst_wbv", {31'h0, wb_valid}, 32'd0);
        chk("rst_exc", {31'h0, misalign_exc}, 32'd0);
        chk("rst_wbdata", wb_data, 32'h0);
        chk("rst_excaddr", exc_addr, 32'h0);
        chk("rst_memaddr", mem_addr, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        run_load("lb_103", 1'b0, 3'b000, 32'h0000_0103, 32'h80FF_1234, 5'd5, 32'hFFFF_FF80);
        run_load("lhu_102", 1'b0, 3'b101, 32'h0000_0102, 32'hBEEF_0000, 5'd6, 32'h0000_BEEF);
        run_load("lh_102", 1'b0, 3'b001, 32'h0000_0102, 32'hBEEF_0000, 5'd7, 32'hFFFF_BEEF);
        run_load("lbu_101", 1'b0, 3'b100, 32'h0000_0101, 32'h0000_A500, 5'd8, 32'h0000_00A5);
        run_load("lw_both", 1'b1, 3'b010, 32'h0000_0104, 32'h1234_5678, 5'd9, 32'h1234_5678);
        run_load("ld_f3_111", 1'b0, 3'b111, 32'h0000_0108, 32'hFFFF_FFFF, 5'd10, 32'h0);

        run_store("sb_201", 3'b000, 32'h0000_0201, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB, 4);
        run_store("sh_202", 3'b001, 32'h0000_0202, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF, 0);
        run_store("sw_300", 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 0);

        run_mis("lw_302", 1'b1, 3'b010, 32'h0000_0302);
        run_mis("lhu_105", 1'b1, 3'b101, 32'h0000_0105);
        run_mis("sh_203", 1'b0, 3'b001, 32'h0000_0203);
        run_mis("st_f3_011", 1'b0, 3'b011, 32'h0000_0400);

        // Reset asserted while the load waits for data.
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hCAFE_F00D;
        accept(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd11);
        step();                                      // REQ
        ex_valid = 1'b0;
        step();                                      // WAIT
        chk("rstw_pre_stall", {31'h0, lsu_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_stall", {31'h0, lsu_stall}, 32'd0);
        chk("rstw_req", {31'h0, mem_req}, 32'd0);
        chk("rstw_wbv", {31'h0, wb_valid}, 32'd0);
        chk("rstw_memaddr", mem_addr, 32'h0);
        chk("rstw_wbrd", {27'h0, wb_rd}, 32'd0);
        step();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstw_no_wbv", {31'h0, wb_valid}, 32'd0);
            chk("rstw_no_stall", {31'h0, lsu_stall}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
